// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, reset PC and the
// fetch-stage state encoding.
package riscv_pkg;

   localparam int          XLEN             = 64;
   localparam int          ILEN             = 32;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      FULL = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, keeps at most one instruction-memory
// request outstanding, and buffers the returned word with its PC for decode.
// A redirect from a later stage retargets the PC and kills any in-flight
// or buffered fetch.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       fetch request handshake (addr word aligned)
//   imem_rsp_valid/data             one-cycle response pulse per accepted request
//   redirect_valid/pc               branch/jump/exception redirect
//   if_valid/instr/pc, dec_ready    instruction handoff to decode
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | request presented at pc, waiting for memory to accept it
// WAIT  | request accepted, waiting for the response pulse
// FULL  | buffer holds an instruction for decode
import riscv_pkg::*;

module fetch_unit #(
   parameter int               XLEN     = riscv_pkg::XLEN,
   parameter int               ILEN     = riscv_pkg::ILEN,
   parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [ILEN-1:0]  imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             if_valid,
   output logic [ILEN-1:0]  if_instr,
   output logic [XLEN-1:0]  if_pc,
   input  logic             dec_ready
);

   fetch_state_t    state;
   logic            drop;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] redirect_target;
   logic            req_fire;
   logic            unused_redirect_lsbs;

   assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign pc_inc               = pc + XLEN'(INSTR_BYTES);

   // The request is held low while reset is asserted even though the state
   // register already sits in REQ, so memory never sees a request during reset.
   assign imem_req_valid = (state == REQ) && rst_n;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A redirect kills the buffered instruction in the same cycle it arrives.
   assign if_valid = (state == FULL) && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= REQ;
         drop     <= 1'b0;
         pc       <= RESET_PC;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         unique case (state)
            REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_target;
               end
               if (req_fire) begin
                  state <= WAIT;
                  // The request just accepted targets the old pc; its
                  // response must be thrown away.
                  if (redirect_valid) begin
                     drop <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  pc <= redirect_target;
                  if (imem_rsp_valid) begin
                     drop  <= 1'b0;
                     state <= REQ;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= REQ;
                  end else begin
                     if_instr <= imem_rsp_data;
                     if_pc    <= pc;
                     pc       <= pc_inc;
                     state    <= FULL;
                  end
               end
            end
            FULL: begin
               if (redirect_valid) begin
                  pc    <= redirect_target;
                  state <= REQ;
               end else if (dec_ready) begin
                  state <= REQ;
               end
            end
            default: begin
               state <= REQ;
               drop  <= 1'b0;
            end
         endcase
      end
   end

endmodule
